pwm_song_controller: RTL and testbench
======================================

# pwm_song_controller

Sequences the phase-generator/PWM audio datapath through a writable table of notes. Each table entry holds a 32-bit phase delta and an 8-bit duration. The block plays entries in order and drives the phase generator's delta input plus a gate that mutes the PWM output during rests and inter-note gaps. It sits between the board top (buttons/host write port) and the phase generator, replacing a fixed note sequencer.

## Interface
Parameters:
- NOTE_COUNT, 16, table depth; power of two, ≥2.
- TEMPO_TICKS, 1_562_500, clocks per duration unit (1/16 s at 25 MHz); ≥1.
- GAP_CYCLES, 250_000, silent clocks after each note; 0 allowed.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  table write strobe.
- i_wr_addr  in  $clog2(NOTE_COUNT)  table write address.
- i_wr_data  in  40  {duration[39:32], phase_delta[31:0]}.
- i_start  in  1  start pulse.
- i_stop  in  1  stop pulse.
- i_loop  in  1  level; restart at entry 0 at end of song.
- o_phase_delta  out  32  delta to phase generator.
- o_phase_delta_valid  out  1  one-cycle pulse when o_phase_delta changes.
- o_gate  out  1  1 = sound; the top ANDs it with the PWM output.
- o_busy  out  1  high in any state except IDLE.
- o_note_index  out  $clog2(NOTE_COUNT)  entry currently fetched/playing.
- o_done  out  1  one-cycle pulse on natural song end.

## Operation
- Table: register array, combinational read, synchronous write, never reset. Writes are accepted in every state. The entry being played was latched at fetch, so rewriting it does not alter the current note.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - i_start && !i_stop → index=0, go to FETCH.
  - Otherwise stay.
- FETCH (exactly 1 cycle): evaluate entry[index].
  - Duration 0 is the end marker.
    - If i_loop=1 and index≠0: index=0, stay in FETCH.
    - Otherwise: pulse o_done, go to IDLE.
  - Duration D≠0:
    - Latch o_phase_delta ← delta and pulse o_phase_delta_valid.
    - Set o_gate = (delta≠0); delta 0 is a rest.
    - Load counters, go to PLAY.
- PLAY: lasts exactly D×TEMPO_TICKS cycles.
  - Implemented as a prescaler (0..TEMPO_TICKS-1) plus an 8-bit unit down-counter; no D×TEMPO_TICKS multiply.
  - On exit: o_gate=0; go to GAP if GAP_CYCLES>0, else advance.
- GAP: lasts exactly GAP_CYCLES cycles with gate low, then advance.
- Advance:
  - index<NOTE_COUNT-1 → index+1, go to FETCH.
  - index=NOTE_COUNT-1 → treated as an end marker: loop to index 0 via FETCH if i_loop=1, else pulse o_done and go to IDLE.
- i_stop in any non-IDLE state:
  - Next state IDLE; o_gate=0; o_phase_delta←0 with a valid pulse.
  - No o_done pulse.
  - Stop wins over start and over every state transition in the same cycle.
- i_start while busy: ignored.

## Timing
- Reset (async assert, sync deassert at the top): state IDLE; o_phase_delta=0; o_phase_delta_valid=0; o_gate=0; o_busy=0; o_note_index=0; o_done=0. Reset mid-song aborts immediately; table contents are preserved.
- i_start sampled at edge k: FETCH during cycle k..k+1. At edge k+1, o_phase_delta, o_gate and o_phase_delta_valid are updated; valid is high for one cycle.
- Per-note period = 1 + D×TEMPO_TICKS + GAP_CYCLES cycles. The gate is high for exactly D×TEMPO_TICKS of those cycles (0 for a rest).
- o_done asserts in the cycle after the terminating FETCH/advance edge. o_busy falls on the same edge.
- o_phase_delta holds its value through GAP and IDLE (gate provides silence) until the next fetch or stop.
- Loop restart adds one FETCH cycle and no gap beyond the normal GAP.

## Test plan
Bench uses NOTE_COUNT=4, TEMPO_TICKS=4, GAP_CYCLES=2.
- Single note: table {D=2, delta=75_591}, then {D=0}; pulse start → valid pulse with delta 75_591 one edge later; gate high exactly 8 cycles, then low 2; FETCH of entry 1 → o_done pulse; o_busy low; total busy 1+8+2+1 = 12 cycles.
- Rest and full table: entries {1,100},{1,0},{1,200},{1,300}, no end marker; gate pattern 4 high, 2 low, 4 low (rest), 2 low, 4 high, …; o_note_index 0→1→2→3; o_done after entry 3's gap with no fifth fetch.
- Loop: same table as the single-note case, i_loop=1 → delta 75_591 repeats every 12 cycles, o_done never pulses; entry 0 set to D=0 with i_loop=1 → o_done two cycles after start (no lockup).
- Stop mid-PLAY and start+stop same cycle: stop on 3rd PLAY cycle → next edge gate=0, o_phase_delta=0 with a valid pulse, IDLE, no o_done; start and stop asserted together in IDLE → stays IDLE.
- Live write: rewrite the currently playing entry during PLAY → current note unchanged; the new value plays on the next loop pass.
- Async reset mid-GAP: all outputs reach reset values without a clock edge; after release, start replays the preserved table from entry 0.

Source files
------------

// File: rtl/pwm_song_controller.sv
// rtl/pwm_song_controller.sv - note-table sequencer driving phase delta and PWM gate
// Plays {duration, phase_delta} entries in order with per-note gap; stop/loop/live-write capable.
module pwm_song_controller #(
  parameter int unsigned NOTE_COUNT  = 16,
  parameter int unsigned TEMPO_TICKS = 1_562_500,
  parameter int unsigned GAP_CYCLES  = 250_000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [$clog2(NOTE_COUNT)-1:0] i_wr_addr,
  input  logic [39:0]                   i_wr_data,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_loop,
  output logic [31:0]                   o_phase_delta,
  output logic                          o_phase_delta_valid,
  output logic                          o_gate,
  output logic                          o_busy,
  output logic [$clog2(NOTE_COUNT)-1:0] o_note_index,
  output logic                          o_done
);
  localparam int            IW         = $clog2(NOTE_COUNT);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NOTE_COUNT - 1);
  localparam logic [31:0]   TEMPO_LAST = 32'(TEMPO_TICKS - 1);
  localparam logic [31:0]   GAP_LAST   = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [31:0]   phase_q, phase_d;
  logic          valid_q, valid_d;
  logic          gate_q, gate_d;
  logic          done_q, done_d;
  logic [31:0]   pre_q, pre_d;
  logic [7:0]    units_q, units_d;
  logic [31:0]   gap_q, gap_d;
  logic          advance;

  logic [39:0]   mem_q [NOTE_COUNT];
  logic [39:0]   rd_entry;
  logic [7:0]    rd_dur;
  logic [31:0]   rd_delta;

  // Table is deliberately never reset so a song survives a reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  assign rd_entry = mem_q[index_q];
  assign rd_dur   = rd_entry[39:32];
  assign rd_delta = rd_entry[31:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      units_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      units_q <= units_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    gate_d  = gate_q;
    done_d  = 1'b0;
    pre_d   = pre_q;
    units_d = units_q;
    gap_d   = gap_q;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          index_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rd_dur == 8'd0) begin
          if (i_loop && index_q != '0) begin
            index_d = '0;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          phase_d = rd_delta;
          valid_d = 1'b1;
          gate_d  = (rd_delta != 32'd0);
          units_d = rd_dur;
          pre_d   = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        // Prescaler counts TEMPO_TICKS clocks per duration unit.
        if (pre_q == TEMPO_LAST) begin
          pre_d = '0;
          if (units_q == 8'd1) begin
            gate_d = 1'b0;
            if (GAP_CYCLES != 0) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            units_d = units_q - 8'd1;
          end
        end else begin
          pre_d = pre_q + 32'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) advance = 1'b1;
        else                   gap_d = gap_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (index_q != LAST_IDX) begin
        index_d = index_q + 1'b1;
        state_d = FETCH;
      end else if (i_loop) begin
        index_d = '0;
        state_d = FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    // Stop overrides everything decided above.
    if (i_stop && state_q != IDLE) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      phase_d = '0;
      valid_d = 1'b1;
      done_d  = 1'b0;
    end
  end

  assign o_phase_delta       = phase_q;
  assign o_phase_delta_valid = valid_q;
  assign o_gate              = gate_q;
  assign o_busy              = (state_q != IDLE);
  assign o_note_index        = index_q;
  assign o_done              = done_q;

endmodule

// File: tb/tb_pwm_song_controller.sv
// tb/tb_pwm_song_controller.sv - self-checking bench for pwm_song_controller
// Per-cycle expected outputs are queued as stimulus is applied and compared at negedge.
module tb_pwm_song_controller;
  localparam int T = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [39:0] wr_data;
  logic        start, stop, loop_en;
  logic [31:0] o_phase_delta;
  logic        o_phase_delta_valid, o_gate, o_busy, o_done;
  logic [1:0]  o_note_index;

  always #5 clk = ~clk;

  pwm_song_controller #(.NOTE_COUNT(4), .TEMPO_TICKS(T), .GAP_CYCLES(G)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_loop(loop_en),
    .o_phase_delta(o_phase_delta), .o_phase_delta_valid(o_phase_delta_valid),
    .o_gate(o_gate), .o_busy(o_busy), .o_note_index(o_note_index), .o_done(o_done)
  );

  typedef struct {
    logic        gate;
    logic        valid;
    logic [31:0] delta;
    logic        busy;
    logic        done;
    logic        chk_idx;
    logic [1:0]  idx;
  } exp_t;

  typedef struct {
    logic [7:0]  dur;
    logic [31:0] delta;
    int          play;
    logic        gate;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[4];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  string       tag      = "init";
  logic [31:0] held     = 32'd0;

  always @(posedge clk) cyc++;

  task automatic push(input logic g, input logic v, input logic [31:0] d, input logic b,
                      input logic dn, input logic ci, input logic [1:0] ix);
    exp_t e;
    e.gate = g; e.valid = v; e.delta = d; e.busy = b; e.done = dn; e.chk_idx = ci; e.idx = ix;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input logic [1:0] ix, input logic [31:0] d);
    push(1'b0, 1'b0, d, 1'b1, 1'b0, 1'b1, ix);
  endtask

  task automatic push_note(input logic [31:0] d, input int play, input logic g, input logic [1:0] ix);
    for (int i = 0; i < play; i++) push(g, (i == 0), d, 1'b1, 1'b0, 1'b1, ix);
    for (int i = 0; i < G; i++) push(1'b0, 1'b0, d, 1'b1, 1'b0, 1'b1, ix);
  endtask

  task automatic push_done(input logic [31:0] d);
    push(1'b0, 1'b0, d, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic push_idle(input logic [31:0] d);
    push(1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (o_gate !== e.gate || o_phase_delta_valid !== e.valid || o_phase_delta !== e.delta ||
          o_busy !== e.busy || o_done !== e.done || (e.chk_idx && o_note_index !== e.idx)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got gate=%b valid=%b delta=%0d busy=%b done=%b idx=%0d; want gate=%b valid=%b delta=%0d busy=%b done=%b idx=%0d(chk=%b)",
                 tag, cyc, o_gate, o_phase_delta_valid, o_phase_delta, o_busy, o_done, o_note_index,
                 e.gate, e.valid, e.delta, e.busy, e.done, e.idx, e.chk_idx);
      end
    end
  endtask

  task automatic drain();
    while (sb.size() != 0) step();
  endtask

  task automatic chk_reset(input string name);
    n_checks++;
    if (o_gate !== 1'b0 || o_phase_delta_valid !== 1'b0 || o_phase_delta !== 32'd0 ||
        o_busy !== 1'b0 || o_done !== 1'b0 || o_note_index !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got gate=%b valid=%b delta=%0d busy=%b done=%b idx=%0d; want all zero",
               name, o_gate, o_phase_delta_valid, o_phase_delta, o_busy, o_done, o_note_index);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic [31:0] delta);
    wr_en = 1'b1; wr_addr = a; wr_data = {d, delta};
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd2,   32'd75_591,      8,    1'b1};
    vecs[1] = '{8'd1,   32'd0,           4,    1'b0};
    vecs[2] = '{8'd3,   32'hFFFF_FFFF,   12,   1'b1};
    vecs[3] = '{8'd255, 32'd1,           1020, 1'b1};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-note songs, one per table vector.
    for (int v = 0; v < 4; v++) begin
      tag = $sformatf("single_note_%0d", v);
      wr(2'd0, vecs[v].dur, vecs[v].delta);
      wr(2'd1, 8'd0, 32'd0);
      push_fetch(2'd0, held);
      start = 1'b1; step(); start = 1'b0;
      push_note(vecs[v].delta, vecs[v].play, vecs[v].gate, 2'd0);
      push_fetch(2'd1, vecs[v].delta);
      push_done(vecs[v].delta);
      push_idle(vecs[v].delta);
      drain();
      held = vecs[v].delta;
    end

    tag = "full_table";
    wr(2'd0, 8'd1, 32'd100);
    wr(2'd1, 8'd1, 32'd0);
    wr(2'd2, 8'd1, 32'd200);
    wr(2'd3, 8'd1, 32'd300);
    push_fetch(2'd0, held);
    start = 1'b1; step(); start = 1'b0;
    push_note(32'd100, 4, 1'b1, 2'd0); push_fetch(2'd1, 32'd100);
    push_note(32'd0,   4, 1'b0, 2'd1); push_fetch(2'd2, 32'd0);
    push_note(32'd200, 4, 1'b1, 2'd2); push_fetch(2'd3, 32'd200);
    push_note(32'd300, 4, 1'b1, 2'd3);
    push_done(32'd300);
    push_idle(32'd300); push_idle(32'd300);
    drain();

    tag = "loop";
    wr(2'd0, 8'd2, 32'd75_591);
    wr(2'd1, 8'd0, 32'd0);
    loop_en = 1'b1;
    push_fetch(2'd0, 32'd300);
    start = 1'b1; step(); start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      push_note(32'd75_591, 8, 1'b1, 2'd0);
      push_fetch(2'd1, 32'd75_591);
      push_fetch(2'd0, 32'd75_591);
    end
    drain();
    stop = 1'b1;
    push(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(); stop = 1'b0;
    push_idle(32'd0);
    step();

    tag = "loop_zero_entry";
    wr(2'd0, 8'd0, 32'd0);
    push_fetch(2'd0, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    push_done(32'd0);
    push_idle(32'd0); push_idle(32'd0);
    drain();
    loop_en = 1'b0;

    tag = "stop_mid_play";
    wr(2'd0, 8'd2, 32'd75_591);
    push_fetch(2'd0, 32'd0);
    for (int i = 0; i < 3; i++) push(1'b1, (i == 0), 32'd75_591, 1'b1, 1'b0, 1'b1, 2'd0);
    start = 1'b1; step(); start = 1'b0;
    drain();
    stop = 1'b1;
    push(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(); stop = 1'b0;
    push_idle(32'd0);
    step();

    tag = "start_and_stop";
    start = 1'b1; stop = 1'b1;
    push_idle(32'd0); push_idle(32'd0); push_idle(32'd0);
    step(); start = 1'b0; stop = 1'b0;
    drain();

    tag = "live_write";
    loop_en = 1'b1;
    push_fetch(2'd0, 32'd0);
    push_note(32'd75_591, 8, 1'b1, 2'd0);
    push_fetch(2'd1, 32'd75_591);
    push_fetch(2'd0, 32'd75_591);
    push_note(32'd500, 4, 1'b1, 2'd0);
    push_fetch(2'd1, 32'd500);
    push_fetch(2'd0, 32'd500);
    start = 1'b1; step(); start = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {8'd1, 32'd500};
    step(); wr_en = 1'b0;
    drain();
    stop = 1'b1;
    push(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(); stop = 1'b0;
    push_idle(32'd0);
    step();
    loop_en = 1'b0;

    tag = "async_reset";
    wr(2'd0, 8'd2, 32'd75_591);
    push_fetch(2'd0, 32'd0);
    push_note(32'd75_591, 8, 1'b1, 2'd0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    sb.delete();
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset_mid_gap");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tag = "replay_after_reset";
    push_fetch(2'd0, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    push_note(32'd75_591, 8, 1'b1, 2'd0);
    push_fetch(2'd1, 32'd75_591);
    push_done(32'd75_591);
    push_idle(32'd75_591);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
